// File: rtl/dpram_burst_reader.sv
// Burst reader: streams a contiguous, wrapping run of DPRAM words out through a valid/ready port.
// Optional m_last output is enabled by defining DPRAM_BURST_READER_LAST_EN.
module dpram_burst_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [AW:0]      start_len,
    output logic             busy,
    output logic             done,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    input  logic [WIDTH-1:0] ram_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
`ifdef DPRAM_BURST_READER_LAST_EN
    ,
    output logic             m_last
`endif
);

    typedef enum logic {IDLE, READ} state_t;

    state_t           state_reg;
    logic [AW-1:0]    addr_reg;
    logic [AW:0]      remaining_reg;
    logic             inflight_reg;
    logic [1:0]       count_reg;
    logic             rd_ptr_reg;
    logic             wr_ptr_reg;
    logic             done_reg;
    logic [WIDTH-1:0] fifo_data_reg [2];

    logic             pop;
    logic             push;
    logic             issue;
    logic             final_pop;
    logic [2:0]       occupancy;
    logic [AW:0]      len_clamped;

    assign pop       = (count_reg != 2'd0) && m_ready;
    assign push      = inflight_reg;
    // Words that will be held after this edge; a new read is only allowed if it still fits.
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue     = (state_reg == READ) && (remaining_reg != '0) && (occupancy < 3'd2);
    assign final_pop = (state_reg == READ) && (remaining_reg == '0) && !inflight_reg
                       && (count_reg == 2'd1) && pop;

    assign len_clamped = (start_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : start_len;

    assign busy     = (state_reg == READ);
    assign done     = done_reg;
    assign ram_en   = issue;
    assign ram_we   = 1'b0;
    assign ram_addr = issue ? addr_reg : '0;
    assign m_valid  = (count_reg != 2'd0);
    assign m_data   = fifo_data_reg[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            inflight_reg  <= 1'b0;
            count_reg     <= 2'd0;
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            inflight_reg <= issue;
            count_reg    <= count_reg + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case (state_reg)
                IDLE: begin
                    if (start && (start_len != '0)) begin
                        addr_reg      <= start_addr;
                        remaining_reg <= len_clamped;
                        state_reg     <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_reg      <= addr_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                    end
                    if (final_pop) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    fifo_data_reg[gi] <= '0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    fifo_data_reg[gi] <= ram_dout;
            end
        end
    endgenerate

`ifdef DPRAM_BURST_READER_LAST_EN
    logic       inflight_last_reg;
    logic [1:0] fifo_last_reg;

    // The last flag follows its read through the RAM latency alongside inflight_reg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inflight_last_reg <= 1'b0;
        else
            inflight_last_reg <= issue && (remaining_reg == (AW+1)'(1));
    end

    generate
        for (gi = 0; gi < 2; gi++) begin : g_last
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    fifo_last_reg[gi] <= 1'b0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    fifo_last_reg[gi] <= inflight_last_reg;
            end
        end
    endgenerate

    assign m_last = fifo_last_reg[rd_ptr_reg];
`endif

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Self-checking bench for dpram_burst_reader: directed cases plus random bursts against a queue model.
module tb_dpram_burst_reader;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst, start, busy, done, ram_en, ram_we, m_valid, m_ready;
    logic [AW-1:0]    start_addr, ram_addr;
    logic [AW:0]      start_len;
    logic [WIDTH-1:0] ram_dout, m_data;
`ifdef DPRAM_BURST_READER_LAST_EN
    logic             m_last;
`endif

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_data [$];
    logic [AW-1:0]    exp_addr [$];
    logic             exp_last [$];
    logic             busy_exp, done_exp, prev_stall;
    logic [WIDTH-1:0] prev_data;
    int               issued, popped, pops_left;

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    dpram_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .start_len(start_len),
        .busy(busy), .done(done), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef DPRAM_BURST_READER_LAST_EN
        , .m_last(m_last)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_data.delete(); exp_addr.delete(); exp_last.delete();
        busy_exp = 1'b0; done_exp = 1'b0; prev_stall = 1'b0; prev_data = '0;
        issued = 0; popped = 0; pops_left = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},   32'(busy),     0);
        check({tag, "_done"},   32'(done),     0);
        check({tag, "_ram_en"}, 32'(ram_en),   0);
        check({tag, "_ram_we"}, 32'(ram_we),   0);
        check({tag, "_valid"},  32'(m_valid),  0);
        check({tag, "_addr"},   32'(ram_addr), 0);
        check({tag, "_data"},   32'(m_data),   0);
`ifdef DPRAM_BURST_READER_LAST_EN
        check({tag, "_last"},   32'(m_last),   0);
`endif
    endtask

    // Called at a negedge with inputs already driven; checks this cycle, then advances one clock.
    task automatic tick();
        logic pop;
        int   n, a;
        #1;
        check("busy", 32'(busy), 32'(busy_exp));
        check("done", 32'(done), 32'(done_exp));
        check("we", 32'(ram_we), 0);
        if (prev_stall) begin
            check("stall_valid", 32'(m_valid), 1);
            check("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (ram_en) begin
            check("addr_expected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) check("ram_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
            issued++;
        end
        pop = m_valid && m_ready;
        if (pop) begin
            check("data_expected", 32'(exp_data.size() != 0), 1);
            if (exp_data.size() != 0) begin
                check("m_data", 32'(m_data), 32'(exp_data.pop_front()));
`ifdef DPRAM_BURST_READER_LAST_EN
                check("m_last", 32'(m_last), 32'(exp_last[0]));
`endif
                void'(exp_last.pop_front());
            end
            popped++;
        end
        check("buffered_le2", 32'((issued - popped) <= 2), 1);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        done_exp   = 1'b0;
        if (pop && busy_exp) begin
            pops_left--;
            if (pops_left == 0) begin
                done_exp = 1'b1;
                busy_exp = 1'b0;
            end
        end else if (!busy_exp && start && (start_len != 0)) begin
            n = (int'(start_len) > DEPTH) ? DEPTH : int'(start_len);
            for (int i = 0; i < n; i++) begin
                a = (int'(start_addr) + i) % DEPTH;
                exp_addr.push_back(AW'(a));
                exp_data.push_back(mem[a]);
                exp_last.push_back(i == n - 1);
            end
            pops_left = n;
            busy_exp  = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input bit rand_ready);
        int guard = 0;
        while ((busy_exp || exp_data.size() != 0) && guard < 200) begin
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check("drain_timeout", 32'(guard < 200), 1);
        m_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int k, p0;
        int pat [6] = '{1, 0, 0, 1, 0, 1};
        rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0; m_ready = 1'b0;
        mem[0] = 8'ha0; mem[1] = 8'ha1; mem[2] = 8'h12; mem[3] = 8'h87;
        reset_model();
        @(negedge clk);
        check_zero("in_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero("after_rst");

        // Case 1: addr 0, len 4, sink always ready
        m_ready = 1'b1; start = 1'b1; start_addr = 2'd0; start_len = 3'd4;
        tick();
        start = 1'b0;
        k = 0;
        while (!m_valid && k < 10) begin tick(); k++; end
        check("first_valid_latency", 32'(k), 2);
        for (int i = 0; i < 4; i++) begin
            check("sustain_valid", 32'(m_valid), 1);
            tick();
        end
        drain(0);

        // Case 2: wrapping burst addr 3, len 3
        start = 1'b1; start_addr = 2'd3; start_len = 3'd3;
        tick();
        start = 1'b0;
        drain(0);

        // Case 3: stalled sink pattern 1,0,0,1,0,1
        p0 = popped;
        start = 1'b1; start_addr = 2'd1; start_len = 3'd4; m_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 40 && (busy_exp || exp_data.size() != 0); j++) begin
            m_ready = 1'(pat[j % 6]);
            tick();
        end
        drain(0);
        check("stall_word_count", 32'(popped - p0), 4);

        // Case 4: len 0 ignored, start while busy ignored
        p0 = popped;
        start = 1'b1; start_addr = 2'd2; start_len = 3'd0;
        tick();
        check("len0_no_busy", 32'(busy), 0);
        start_len = 3'd2;
        tick();
        start_addr = 2'd0;
        tick();
        tick();
        start = 1'b0;
        drain(0);
        check("ignored_word_count", 32'(popped - p0), 2);

        // Case 5: reset after the 2nd word of a len 4 burst
        p0 = popped;
        start = 1'b1; start_addr = 2'd0; start_len = 3'd4;
        tick();
        start = 1'b0;
        k = 0;
        while ((popped - p0) < 2 && k < 20) begin tick(); k++; end
        check("pre_rst_words", 32'(popped - p0), 2);
        #2 rst = 1'b1;
        #1 check_zero("mid_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 6; i++) begin
            check("no_stale_valid", 32'(m_valid), 0);
            tick();
        end

        // Case 6: random bursts with random sink readiness
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
            start = 1'b1;
            start_addr = AW'($urandom_range(0, DEPTH - 1));
            start_len = 3'($urandom_range(0, 7));
            m_ready = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            drain(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
